fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end for the RV32I core: generates sequential fetch PCs,
//  issues requests to a handshaked instruction memory with up to DEPTH in flight, and buffers
//  returned words in a DEPTH-entry FIFO of {pc, insn} pairs for the decode stage.
//  Accepts branch/jump redirects from execute. Replaces the single-cycle PC register + direct
//  imemory read in the core top.
// PARAMETERS
//  XLEN      32            address / PC width
//  DEPTH     4             FIFO entries = max (queued + outstanding) fetches; power of 2, >=2
//  RESET_PC  32'h0100_0000 PC loaded on reset (instruction memory base)
// PORTS
//  clock           in   1     rising-edge clock
//  reset           in   1     asynchronous, active-high
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request this cycle
//  imem_req_addr   out  XLEN  word-aligned fetch address
//  imem_resp_valid in   1     response word valid; responses return in request order
//  imem_resp_data  in   32    instruction word
//  redirect_valid  in   1     flush and restart fetch (taken branch / JAL / JALR)
//  redirect_pc     in   XLEN  restart address; bits [1:0] forced to 0
//  if_valid        out  1     head entry valid toward decode
//  if_ready        in   1     decode consumes head this cycle
//  if_pc           out  XLEN  PC of head entry
//  if_insn         out  32    instruction of head entry
//  occupancy       out  $clog2(DEPTH)+1  entries currently in FIFO
// BEHAVIOUR
//  - Reset (async): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0; imem_req_valid=0,
//    if_valid=0, if_pc=0, if_insn=0, occupancy=0. First request in first cycle after reset drops.
//  - Request: imem_req_valid = !redirect_valid && (occupancy + outstanding < DEPTH);
//    imem_req_addr = fetch_pc. On valid&&ready: outstanding++, fetch_pc += 4 (wraps mod 2^XLEN,
//    0xFFFF_FFFC -> 0x0000_0000). Request address/valid stable while held without ready.
//  - Each request's PC is recorded in a DEPTH-entry in-flight PC queue to tag its response.
//  - Response: on imem_resp_valid: outstanding--. If drop>0: drop--, word discarded.
//    Else {tag pc, data} written to FIFO tail; visible on if_* the NEXT cycle (1-cycle latency,
//    no bypass). Response without outstanding request is a protocol error (assert in sim).
//  - Dequeue: if_valid && if_ready pops head; if_* hold stable while if_valid && !if_ready.
//  - Simultaneous push and pop: occupancy unchanged; full FIFO + pop + push legal.
//  - Credit rule guarantees FIFO never overflows; no response is ever back-pressured.
//  - Redirect (registered effect at clock edge): FIFO cleared, fetch_pc = {redirect_pc[XLEN-1:2],2'b00},
//    drop = outstanding after this cycle's request/response accounting (a response arriving
//    in the redirect cycle is discarded; no request issued in the redirect cycle).
//    Next cycle: if_valid=0, imem_req_valid=1 at the new PC.
//  - Redirect wins over simultaneous dequeue and enqueue; back-to-back redirects: latest wins,
//    drop accumulates all still-outstanding requests.
//  - Reset mid-operation: all state cleared immediately; late memory responses are the
//    memory model's responsibility (bench resets memory together).
// TESTING
//  1 Reset, 1-cycle mem, if_ready=1 -> req addrs 0x01000000,04,08,...; if_pc follows, 1 insn/cycle steady.
//  2 if_ready=0, DEPTH=4 -> exactly 4 requests accepted, occupancy=4, imem_req_valid=0; release -> drains in order.
//  3 2-cycle mem, 2 outstanding, redirect_pc=0x01000103 -> both responses dropped, next if_pc=0x01000100.
//  4 Redirect same cycle as resp_valid and if_ready pop -> FIFO empty next cycle, response discarded.
//  5 redirect_pc=0xFFFFFFF8 -> fetch 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
//  6 Assert reset with FIFO full mid-stream -> outputs zero same cycle; restart at 0x01000000.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch front end. Issues word fetches to a handshaked
// instruction memory, limits (buffered + in-flight) fetches to DEPTH so the decode buffer can
// never overflow, tags each response with its request PC and presents {pc, insn} to decode.
// A redirect flushes the buffer and squashes every response still owed by the memory.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0100_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [31:0]            imem_resp_data,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [XLEN-1:0]        if_pc,
  output logic [31:0]            if_insn,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned   PtrW     = $clog2(DEPTH);
  localparam int unsigned   CntW     = PtrW + 1;
  localparam logic [CntW:0] DepthSum = (CntW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] tag_rd_q, tag_rd_d;
  logic [PtrW-1:0] tag_wr_q, tag_wr_d;

  logic [XLEN-1:0] fifo_pc_q   [DEPTH];
  logic [31:0]     fifo_insn_q [DEPTH];
  logic [XLEN-1:0] tag_pc_q    [DEPTH];

  logic            req_fire;
  logic            resp_drop;
  logic            push;
  logic            pop;
  logic [CntW:0]   credit_used;
  logic            unused_redirect_lsb;

  // Low address bits of a redirect target are ignored; fetches are always word aligned.
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credit: every buffered entry and every in-flight request owns one buffer slot.
  assign credit_used    = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < DepthSum);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop = (drop_q != '0);
  assign push      = imem_resp_valid && !resp_drop && !redirect_valid;
  assign if_valid  = (count_q != '0);
  assign pop       = if_valid && if_ready && !redirect_valid;

  // Empty buffer presents zeros so the outputs are clean right after reset or a flush.
  assign if_pc     = if_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign if_insn   = if_valid ? fifo_insn_q[rd_ptr_q] : '0;
  assign occupancy = count_q;

  // Next-state for fetch PC, in-flight tracking, squash count and buffer pointers.
  always_comb begin
    outstanding_d = outstanding_q;
    if (req_fire && !imem_resp_valid) begin
      outstanding_d = outstanding_q + CntW'(1);
    end else if (!req_fire && imem_resp_valid) begin
      outstanding_d = outstanding_q - CntW'(1);
    end

    // The tag queue follows the memory, so it is not touched by a redirect.
    tag_wr_d = req_fire ? tag_wr_q + PtrW'(1) : tag_wr_q;
    tag_rd_d = imem_resp_valid ? tag_rd_q + PtrW'(1) : tag_rd_q;

    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      // Everything still owed after this cycle belongs to the old path.
      drop_d     = outstanding_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (imem_resp_valid && resp_drop) begin
        drop_d = drop_q - CntW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
    end
  end

  // Storage arrays need no reset; validity is carried by the pointers and counts.
  always_ff @(posedge clock) begin
    if (req_fire) begin
      tag_pc_q[tag_wr_q] <= fetch_pc_q;
    end
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= tag_pc_q[tag_rd_q];
      fifo_insn_q[wr_ptr_q] <= imem_resp_data;
    end
  end

  // A response with nothing in flight means the memory broke the protocol.
  resp_has_request: assert property (@(posedge clock) disable iff (reset)
    imem_resp_valid |-> (outstanding_q != '0));

endmodule
